// File: rtl/block_nest_checker.sv
// rtl/block_nest_checker.sv - streaming begin/end nesting checker with depth tracking and sticky error
module block_nest_checker #(
  parameter int DEPTH_W = 8,
  parameter int WS_ALL  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err
);

  typedef enum logic [3:0] {
    IDLE,
    OTHER,
    B1,
    B2,
    B3,
    B4,
    BN,
    E1,
    E2,
    ED
  } state_t;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;

  logic [7:0] ch_lc;
  logic       is_delim;

  // Fold upper-case letters onto lower case and classify the delimiter set
  always_comb begin
    ch_lc = in;
    if (in >= 8'h41 && in <= 8'h5A) begin
      ch_lc = in | 8'h20;
    end
    is_delim = (in == 8'h20);
    if (WS_ALL != 0) begin
      is_delim = is_delim || (in == 8'h09) || (in == 8'h0A) || (in == 8'h0D);
    end
  end

  // Keyword recogniser: tentative depth change on the last letter, undo if the word continues,
  // commit (and raise err for a pending under/overflow) on the delimiter that ends the keyword
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    pend_d  = pend_q;
    err_d   = err_q;
    if (in_valid) begin
      if (is_delim) begin
        state_d = IDLE;
        if ((state_q == BN || state_q == ED) && pend_q) begin
          err_d  = 1'b1;
          pend_d = 1'b0;
        end
      end else begin
        state_d = OTHER;
        case (state_q)
          IDLE: begin
            if (ch_lc == 8'h62) state_d = B1;
            else if (ch_lc == 8'h65) state_d = E1;
          end
          B1: if (ch_lc == 8'h65) state_d = B2;
          B2: if (ch_lc == 8'h67) state_d = B3;
          B3: if (ch_lc == 8'h69) state_d = B4;
          E1: if (ch_lc == 8'h6E) state_d = E2;
          B4: begin
            if (ch_lc == 8'h6E) begin
              state_d = BN;
              if (depth_q != DEPTH_MAX) depth_d = depth_q + 1'b1;
              else pend_d = 1'b1;
            end
          end
          E2: begin
            if (ch_lc == 8'h64) begin
              state_d = ED;
              if (depth_q != DEPTH_ZERO) depth_d = depth_q - 1'b1;
              else pend_d = 1'b1;
            end
          end
          BN: begin
            if (pend_q) pend_d = 1'b0;
            else depth_d = depth_q - 1'b1;
          end
          ED: begin
            if (pend_q) pend_d = 1'b0;
            else depth_d = depth_q + 1'b1;
          end
          default: state_d = OTHER;
        endcase
      end
    end
  end

  // State registers; reset discards any tentative or pending keyword action
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign depth  = depth_q;
  assign err    = err_q;
  assign result = (depth_q == DEPTH_ZERO) & ~err_q & ~pend_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// tb/tb_block_nest_checker.sv - table-driven and model-scoreboarded bench for block_nest_checker
module tb_block_nest_checker;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_c;
  logic       in_valid;
  logic       r0, r1, r2;
  logic       e0, e1, e2;
  logic [7:0] d0;
  logic [1:0] d1;
  logic [7:0] d2;

  block_nest_checker #(.DEPTH_W(8), .WS_ALL(0)) dut0 (
    .clk(clk), .reset(rst_n), .in(in_c), .in_valid(in_valid),
    .result(r0), .depth(d0), .err(e0)
  );
  block_nest_checker #(.DEPTH_W(2), .WS_ALL(0)) dut1 (
    .clk(clk), .reset(rst_n), .in(in_c), .in_valid(in_valid),
    .result(r1), .depth(d1), .err(e1)
  );
  block_nest_checker #(.DEPTH_W(8), .WS_ALL(1)) dut2 (
    .clk(clk), .reset(rst_n), .in(in_c), .in_valid(in_valid),
    .result(r2), .depth(d2), .err(e2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string stim;
    int    inst;
    bit    rst;
    bit    tog;
    string dep;
    string res;
    string er;
  } rec_t;

  typedef struct {
    int    inst;
    int    d;
    bit    r;
    bit    e;
    string tag;
  } exp_t;

  rec_t tbl[9];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model for dut0 (max 255) and dut1 (max 3), space-only delimiter
  int  mb[2], md[2];
  bit  mp[2], me[2];
  byte wb[8];
  int  wl;

  function automatic rec_t mk(string s, int inst, bit rst, bit tog, string dp, string rs, string er);
    rec_t r;
    r.stim = s; r.inst = inst; r.rst = rst; r.tog = tog; r.dep = dp; r.res = rs; r.er = er;
    return r;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      mb[k] = 0; md[k] = 0; mp[k] = 1'b0; me[k] = 1'b0;
    end
    wl = 0;
  endfunction

  function automatic void m_char(byte c);
    byte l;
    bit  kb, ke;
    int  mx;
    l = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    if (c == 8'h20) begin
      for (int k = 0; k < 2; k++) begin
        if (mp[k]) begin me[k] = 1'b1; mp[k] = 1'b0; end
        mb[k] = md[k];
      end
      wl = 0;
    end else begin
      if (wl < 8) wb[wl] = l;
      wl++;
      kb = (wl == 5) && wb[0] == "b" && wb[1] == "e" && wb[2] == "g" && wb[3] == "i" && wb[4] == "n";
      ke = (wl == 3) && wb[0] == "e" && wb[1] == "n" && wb[2] == "d";
      for (int k = 0; k < 2; k++) begin
        mx = (k == 0) ? 255 : 3;
        if (kb) begin
          if (mb[k] < mx) begin md[k] = mb[k] + 1; mp[k] = 1'b0; end
          else begin md[k] = mb[k]; mp[k] = 1'b1; end
        end else if (ke) begin
          if (mb[k] > 0) begin md[k] = mb[k] - 1; mp[k] = 1'b0; end
          else begin md[k] = mb[k]; mp[k] = 1'b1; end
        end else begin
          md[k] = mb[k]; mp[k] = 1'b0;
        end
      end
    end
  endfunction

  task automatic check(int inst, int d, bit r, bit e, string tag);
    int ad;
    bit ar, ae;
    case (inst)
      0: begin ad = int'(d0); ar = r0; ae = e0; end
      1: begin ad = int'(d1); ar = r1; ae = e1; end
      default: begin ad = int'(d2); ar = r2; ae = e2; end
    endcase
    n_vec++;
    if (ad != d || ar != r || ae != e) begin
      n_bad++;
      $display("FAIL %s inst%0d: got depth=%0d result=%0b err=%0b, want depth=%0d result=%0b err=%0b",
               tag, inst, ad, ar, ae, d, r, e);
    end
  endtask

  task automatic push(int inst, int d, bit r, bit e, string tag);
    exp_t x;
    x.inst = inst; x.d = d; x.r = r; x.e = e; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic push_model(string tag);
    for (int k = 0; k < 2; k++) begin
      push(k, md[k], (md[k] == 0) && !me[k] && !mp[k], me[k], tag);
    end
  endtask

  // drive on the falling edge, compare every queued expectation 1 ns after the rising edge
  task automatic step(byte ch, bit v);
    exp_t x;
    @(negedge clk);
    in_c = ch;
    in_valid = v;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check(x.inst, x.d, x.r, x.e, x.tag);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    string words[10];
    string w;
    byte   ch;
    rst_n = 1'b0;
    in_c = 8'h00;
    in_valid = 1'b0;

    tbl[0] = mk("BEGIN end ", 0, 1, 0, "0000111100", "1111000011", "0000000000");
    tbl[1] = mk("begin begin end", 0, 1, 1, "000011111122221", "111100000000000", "000000000000000");
    tbl[2] = mk("begins ende bgin xbegin ", 0, 1, 0, "000010000000000000000000",
                "111101111011111111111111", "000000000000000000000000");
    tbl[3] = mk("end ", 0, 1, 0, "0000", "1100", "0001");
    tbl[4] = mk("begin end ", 0, 0, 0, "0000111100", "0000000000", "1111111111");
    tbl[5] = mk("begin begin begin begin ", 1, 1, 0, "000011111122222233333333",
                "111100000000000000000000", "000000000000000000000001");
    tbl[6] = mk("begin begin begin beginx", 1, 1, 0, "000011111122222233333333",
                "111100000000000000000000", "000000000000000000000000");
    tbl[7] = mk("begin\tend\n", 2, 1, 0, "0000111100", "1111000011", "0000000000");
    tbl[8] = mk("begin\tend\n", 0, 1, 0, "0000100000", "1111011111", "0000000000");

    #2;
    for (int k = 0; k < 3; k++) check(k, 0, 1'b1, 1'b0, "reset");
    do_reset();

    for (int t = 0; t < 9; t++) begin
      if (tbl[t].rst) do_reset();
      for (int i = 0; i < tbl[t].stim.len(); i++) begin
        int  dv;
        bit  rv, ev;
        dv = int'(tbl[t].dep[i]) - 48;
        rv = (tbl[t].res[i] == "1");
        ev = (tbl[t].er[i] == "1");
        push(tbl[t].inst, dv, rv, ev, $sformatf("t%0d[%0d]", t, i));
        step(tbl[t].stim[i], 1'b1);
        if (tbl[t].tog) begin
          push(tbl[t].inst, dv, rv, ev, $sformatf("t%0d[%0d]hold", t, i));
          step(8'h65, 1'b0);
        end
      end
    end

    // async reset in the middle of "begi": no clock edge needed, and the word is forgotten
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 1'b1, 1'b0, "begi");
      step(tbl[0].stim[i], 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check(0, 0, 1'b1, 1'b0, "async_rst_begi");
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 1'b1, 1'b0, "after_rst_n");
    step(8'h6E, 1'b1);

    // async reset discards a pending underflow and an open depth
    do_reset();
    push(0, 0, 1'b1, 1'b0, "pend_e"); step(8'h65, 1'b1);
    push(0, 0, 1'b1, 1'b0, "pend_n"); step(8'h6E, 1'b1);
    push(0, 0, 1'b0, 1'b0, "pend_d"); step(8'h64, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check(0, 0, 1'b1, 1'b0, "async_rst_pend");
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 1'b1, 1'b0, "after_rst_sp");
    step(8'h20, 1'b1);

    // random word stream against the model, both depth widths at once
    words[0] = "begin"; words[1] = "BEGIN"; words[2] = "end";  words[3] = "End";
    words[4] = "begins"; words[5] = "endx"; words[6] = "beg";  words[7] = "en";
    words[8] = "xend";  words[9] = "bEgIn";
    do_reset();
    m_reset();
    for (int n = 0; n < 150; n++) begin
      w = words[$urandom_range(0, 9)];
      for (int i = 0; i < w.len(); i++) begin
        ch = w[i];
        m_char(ch);
        push_model($sformatf("rnd%0d[%0d]", n, i));
        step(ch, 1'b1);
        if ($urandom_range(0, 7) == 0) begin
          push_model($sformatf("rnd%0d[%0d]idle", n, i));
          step(8'h20, 1'b0);
        end
      end
      for (int s = 0; s < int'($urandom_range(1, 2)); s++) begin
        m_char(8'h20);
        push_model($sformatf("rnd%0d_sp", n));
        step(8'h20, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/block_nest_checker.md
Name: block_nest_checker

Overview:
- Streaming keyword checker for the character-input block. Consumes one ASCII character per valid cycle and tracks nesting of case-insensitive whole-word "begin" / "end" tokens.
- Reports three things:
  - balance (result);
  - current nesting depth;
  - a sticky error for underflow ("end" with nothing open) or counter overflow.
- Successor to the single-counter balance checker. Adds a parametrised depth width, an input qualifier, a configurable delimiter set and error detection.

Parameters:
- DEPTH_W, 8, width of nesting depth counter; max depth = 2^DEPTH_W-1.
- WS_ALL, 0, delimiter set: 0 = space (0x20) only; 1 = space, tab (0x09), LF (0x0A), CR (0x0D).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in  input  8  ASCII character.
- in_valid  input  1  character on `in` is consumed this cycle; when 0, no state changes.
- result  output  1  1 when depth==0, no sticky error and no pending error.
- depth  output  DEPTH_W  current open-"begin" count, including a tentative count.
- err  output  1  sticky: underflow or overflow committed.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, depth=0, pend=0, err=0. Hence result=1, depth=0, err=0.
- All updates on posedge clk with reset==1 and in_valid==1. With in_valid==0, every register holds.
- Matching:
  - Letters compare case-insensitively.
  - DELIM = any character in the set selected by WS_ALL.
  - Any non-DELIM character is a word character, including digits and punctuation.
- States:
  - IDLE: between words.
  - OTHER: non-keyword word.
  - B1..B4: "b", "be", "beg", "begi" seen.
  - BN: "begin" complete, tentative.
  - E1, E2: "e", "en" seen.
  - ED: "end" complete, tentative.
- Transitions on DELIM, from any state:
  - IDLE and OTHER go to IDLE.
  - BN and ED go to IDLE and commit (see below).
  - All other states go to IDLE with no effect.
- Transitions on a word character:
  - IDLE: b → B1; e → E1; else OTHER.
  - B1: e → B2. B2: g → B3. B3: i → B4. E1: n → E2. On any other character, go to OTHER.
  - B4: n → BN, with the tentative begin action.
  - E2: d → ED, with the tentative end action.
  - BN / ED: go to OTHER and undo the tentative action.
  - OTHER: stays in OTHER.
- Tentative begin:
  - If depth < max, depth+1.
  - Else depth holds and pend=1 (overflow pending).
- Tentative end:
  - If depth > 0, depth-1.
  - Else depth holds and pend=1 (underflow pending).
- Undo (word continues, e.g. "begins", "endx"):
  - If pend==1, clear pend and leave depth unchanged.
  - Else revert depth by one.
- Commit (DELIM after BN/ED): if pend==1, set err=1 and clear pend. Depth stays.
- err is sticky until reset. After err is set, depth keeps tracking normally, but result stays 0.
- result = (depth==0) & ~err & ~pend. It is registered-state derived, with no combinational path from in/in_valid.
- Latency: depth and result reflect the character consumed at the preceding clock edge. A keyword's effect is visible in the cycle after its last letter; a committed error is visible in the cycle after the delimiter.
- Leading, trailing and repeated delimiters are harmless. A keyword at end of stream without a delimiter remains tentative but is already counted.
- Reset asserted mid-word returns to IDLE immediately and discards any tentative or pending action.

Test Plan:
- Post-reset: "BEGIN end " (valid every cycle) → depth 1 after 'N', 0 after 'd'; result 1 at end; err 0.
- Nesting with gaps: "begin begin end" with in_valid toggling 1/0 → depth 1, 2, 1; result 0; holds values on invalid cycles.
- Non-keywords: "begins ende bgin xbegin " → depth goes 1 then back to 0 after 's'; depth stays 0 for "ende", "bgin" and "xbegin"; result 1 at end.
- Underflow: "end " from reset → after 'd' result 0, depth 0; after ' ' err 1, result stays 0. Then "begin end " → err still 1, result 0.
- Overflow (DEPTH_W=2): four "begin " words → depth 3, err 1 after 4th delimiter. Separate run: "begin begin begin beginx" → depth 3, pend cleared, err 0.
- WS_ALL=1: "begin\tend\n" → result 1, err 0. With WS_ALL=0, same stream is a single non-keyword word "begin\tend\n" → depth 1 after 'n', back to 0 on '\t', stays 0; result 1. Async reset asserted mid-"begi" → depth 0, state IDLE, result 1 without a clock edge.
